instruction_fetch_stage: RTL and testbench

//   IF stage of the pipelined MIPS core: owns the PC, drives the word address
//   of the 1024-word instruction memory, and captures the fetched word into
//   the IF/ID pipeline register for decode. Handles decode stalls and taken

---
 rtl/instruction_fetch_stage_if.sv | 12 +
 rtl/instruction_fetch_stage.sv | 107 ++++++++++
 tb/tb_instruction_fetch_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory bus between the IF stage (master) and the 1024-word
// instruction memory (slave). Address is a word address; read data is a
// combinational function of the address.
interface instruction_fetch_stage_if #(
   parameter int IMEM_AW = 10
);
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_stage.sv
// IF stage of the pipelined MIPS core. Owns the PC, presents the word
// address to instruction memory and captures the fetched word into the
// IF/ID register. Per-edge priority: rst > redirect > stall > fetch.
// A redirect flushes IF/ID with NOP_WORD and clears if_id_valid.
// Optional feature macro: PERF_CNT_EN builds saturating fetch/stall
// counters; without it fetch_count and stall_count read as zero.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 10,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   instruction_fetch_stage_if.master  imem,
   output logic [31:0]                pc,
   output logic [31:0]                if_id_instr,
   output logic [31:0]                if_id_pc_plus4,
   output logic                       if_id_valid,
   output logic [31:0]                fetch_count,
   output logic [31:0]                stall_count
);

   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic [31:0] instr_next;
   logic [31:0] pc_plus4_next;
   logic        valid_next;
   logic        fetch_evt;
   logic        stall_evt;

   // Low target bits are discarded, so the word-aligned PC never uses them.
   logic unused_redirect_bits;
   assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

   // Upper PC bits are ignored here, so memory aliases every 4*2^IMEM_AW bytes.
   assign imem.imem_addr = pc[IMEM_AW+1:2];
   assign pc_plus4       = pc + 32'd4;

   // Next-state selection for PC and IF/ID: redirect beats stall beats fetch.
   always_comb begin
      pc_next       = pc;
      instr_next    = if_id_instr;
      pc_plus4_next = if_id_pc_plus4;
      valid_next    = if_id_valid;
      fetch_evt     = 1'b0;
      stall_evt     = 1'b0;
      if (redirect) begin
         pc_next       = {redirect_pc[31:2], 2'b00};
         instr_next    = NOP_WORD;
         pc_plus4_next = 32'h0000_0000;
         valid_next    = 1'b0;
      end else if (stall) begin
         stall_evt     = 1'b1;
      end else begin
         pc_next       = pc_plus4;
         instr_next    = imem.imem_rdata;
         pc_plus4_next = pc_plus4;
         valid_next    = 1'b1;
         fetch_evt     = 1'b1;
      end
   end

   // PC and IF/ID pipeline register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc             <= RESET_PC;
         if_id_instr    <= NOP_WORD;
         if_id_pc_plus4 <= 32'h0000_0000;
         if_id_valid    <= 1'b0;
      end else begin
         pc             <= pc_next;
         if_id_instr    <= instr_next;
         if_id_pc_plus4 <= pc_plus4_next;
         if_id_valid    <= valid_next;
      end
   end

`ifdef PERF_CNT_EN
   // Saturating performance counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= 32'h0000_0000;
         stall_count <= 32'h0000_0000;
      end else begin
         if (fetch_evt && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
         end else begin
            fetch_count <= fetch_count;
         end
         if (stall_evt && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
         end else begin
            stall_count <= stall_count;
         end
      end
   end
`else
   logic unused_evt;
   assign unused_evt  = fetch_evt ^ stall_evt;
   assign fetch_count = 32'h0000_0000;
   assign stall_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios from
// the fetch-stage behaviour plus a randomized run against a reference model.
module tb_instruction_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   logic [31:0] mem [0:1023];

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pp4;
   logic        m_valid;
   logic [31:0] m_fc;
   logic [31:0] m_sc;

   instruction_fetch_stage_if #(.IMEM_AW(10)) bus ();

   assign bus.imem_rdata = mem[bus.imem_addr];

   instruction_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem           (bus.master),
      .pc             (pc),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Effect of one clock edge on the architectural state of the IF stage.
   task automatic model_edge(input logic r, input logic s, input logic d, input logic [31:0] rpc);
      if (r) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
      end else if (d) begin
         m_pc = rpc & 32'hFFFF_FFFC; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (s) begin
`ifdef PERF_CNT_EN
         if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
`endif
      end else begin
         m_instr = mem[(m_pc / 32'd4) % 32'd1024];
         m_pc    = m_pc + 32'd4;
         m_pp4   = m_pc;
         m_valid = 1'b1;
`ifdef PERF_CNT_EN
         if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
`endif
      end
   endtask

   // Apply inputs from the falling edge, clock once, step the model, return at falling edge.
   task automatic step(input logic r, input logic s, input logic d, input logic [31:0] rpc);
      rst = r; stall = s; redirect = d; redirect_pc = rpc;
      @(posedge clk);
      model_edge(r, s, d, rpc);
      @(negedge clk);
   endtask

   task automatic test_reset;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: got pc=%h instr=%h pp4=%h v=%b, want all zero", pc, if_id_instr, if_id_pc_plus4, if_id_valid);
      end
      tests_run++;
      if ({fetch_count, stall_count, bus.imem_addr} !== {32'h0, 32'h0, 10'h0}) begin
         tests_failed++;
         $display("FAIL reset_counters: got fc=%h sc=%h addr=%h, want 0", fetch_count, stall_count, bus.imem_addr);
      end
   endtask

   task automatic test_sequence;
      logic [31:0] prog [0:3];
      prog[0] = 32'h2008_0001; prog[1] = 32'h2009_0002; prog[2] = 32'h0109_5020; prog[3] = 32'hAC0A_0000;
      for (int i = 0; i < 4; i++) mem[i] = prog[i];
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0);
         tests_run++;
         if ({if_id_instr, if_id_valid} !== {prog[i], 1'b1}) begin
            tests_failed++;
            $display("FAIL seq_instr%0d: got %h/%b want %h/1", i, if_id_instr, if_id_valid, prog[i]);
         end
      end
      tests_run++;
      if ({pc, if_id_pc_plus4} !== {32'h10, 32'h10}) begin
         tests_failed++;
         $display("FAIL seq_pc: got pc=%h pp4=%h want 10/10", pc, if_id_pc_plus4);
      end
   endtask

   task automatic test_stall;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         tests_run++;
         if ({pc, if_id_instr, if_id_valid, bus.imem_addr} !== {32'h8, mem[1], 1'b1, 10'h2}) begin
            tests_failed++;
            $display("FAIL stall_hold%0d: got pc=%h instr=%h v=%b want pc=8 instr=%h v=1", i, pc, if_id_instr, if_id_valid, mem[1]);
         end
      end
      tests_run++;
`ifdef PERF_CNT_EN
      if (stall_count !== 32'd3) begin
`else
      if (stall_count !== 32'd0) begin
`endif
         tests_failed++;
         $display("FAIL stall_count: got %0d", stall_count);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if ({pc, if_id_instr, if_id_pc_plus4} !== {32'hC, mem[2], 32'hC}) begin
         tests_failed++;
         $display("FAIL stall_resume: got pc=%h instr=%h pp4=%h want C/%h/C", pc, if_id_instr, if_id_pc_plus4, mem[2]);
      end
   endtask

   task automatic test_redirect;
      step(1'b0, 1'b0, 1'b1, 32'h20);
      step(1'b0, 1'b0, 1'b1, 32'h43);
      tests_run++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {32'h40, 32'h0, 32'h0, 1'b0}) begin
         tests_failed++;
         $display("FAIL redirect_flush: got pc=%h instr=%h pp4=%h v=%b want 40/0/0/0", pc, if_id_instr, if_id_pc_plus4, if_id_valid);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {32'h44, mem[16], 32'h44, 1'b1}) begin
         tests_failed++;
         $display("FAIL redirect_target: got pc=%h instr=%h want 44/%h", pc, if_id_instr, mem[16]);
      end
   endtask

   task automatic test_redirect_stall;
      step(1'b0, 1'b1, 1'b1, 32'h100);
      tests_run++;
      if ({pc, if_id_instr, if_id_valid, bus.imem_addr} !== {32'h100, 32'h0, 1'b0, 10'h40}) begin
         tests_failed++;
         $display("FAIL redirect_over_stall: got pc=%h instr=%h v=%b want 100/0/0", pc, if_id_instr, if_id_valid);
      end
   endtask

   task automatic test_wrap;
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      tests_run++;
      if ({pc, bus.imem_addr} !== {32'hFFFF_FFFC, 10'h3FF}) begin
         tests_failed++;
         $display("FAIL wrap_top: got pc=%h addr=%h want FFFFFFFC/3FF", pc, bus.imem_addr);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if ({pc, bus.imem_addr, if_id_instr, if_id_pc_plus4} !== {32'h0, 10'h0, mem[1023], 32'h0}) begin
         tests_failed++;
         $display("FAIL wrap_zero: got pc=%h addr=%h instr=%h pp4=%h", pc, bus.imem_addr, if_id_instr, if_id_pc_plus4);
      end
      step(1'b0, 1'b0, 1'b1, 32'h1000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if ({if_id_instr, pc} !== {mem[0], 32'h1004}) begin
         tests_failed++;
         $display("FAIL alias: got instr=%h pc=%h want %h/1004", if_id_instr, pc, mem[0]);
      end
   endtask

   task automatic test_reset_mid_stall;
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h200);
      tests_run++;
      if ({pc, if_id_valid, fetch_count, stall_count} !== {32'h0, 1'b0, 32'h0, 32'h0}) begin
         tests_failed++;
         $display("FAIL reset_mid_stall: got pc=%h v=%b fc=%h sc=%h want 0", pc, if_id_valid, fetch_count, stall_count);
      end
   endtask

   task automatic test_random;
      logic r, s, d;
      logic [31:0] rpc;
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 99) < 3);
         s   = ($urandom_range(0, 99) < 25);
         d   = ($urandom_range(0, 99) < 12);
         rpc = $urandom;
         step(r, s, d, rpc);
         tests_run++;
         if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count, stall_count} !==
             {m_pc, m_instr, m_pp4, m_valid, m_fc, m_sc}) begin
            tests_failed++;
            $display("FAIL random%0d: got pc=%h i=%h p4=%h v=%b fc=%0d sc=%0d want pc=%h i=%h p4=%h v=%b fc=%0d sc=%0d",
                     i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count, stall_count,
                     m_pc, m_instr, m_pp4, m_valid, m_fc, m_sc);
         end
      end
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
      @(negedge clk);
      test_reset;
      test_sequence;
      test_stall;
      test_redirect;
      test_redirect_stall;
      test_wrap;
      test_reset_mid_stall;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
